gauss_window_ctrl: RTL and testbench



---
 rtl/gauss_window_ctrl_if.sv | 61 ++++++
 rtl/gauss_window_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gauss_window_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gauss_window_ctrl_if.sv
// Bus bundle for the 3x3 Gaussian window sequencer: CPU control, data memory,
// window register file and filter handshake. The master side is the sequencer.
interface gauss_window_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              busy;
    logic              done;

    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [7:0]        mem_rdata;

    logic              win_we;
    logic [3:0]        win_addr;
    logic [7:0]        win_pixel;

    logic              flt_start;
    logic              flt_done;
    logic [7:0]        flt_result;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    modport master (
        input  start,
        output busy,
        output done,
        output mem_re,
        output mem_raddr,
        input  mem_rdata,
        output win_we,
        output win_addr,
        output win_pixel,
        output flt_start,
        input  flt_done,
        input  flt_result,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  mem_re,
        input  mem_raddr,
        output mem_rdata,
        input  win_we,
        input  win_addr,
        input  win_pixel,
        input  flt_start,
        output flt_done,
        output flt_result,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );
endinterface

// File: rtl/gauss_window_ctrl.sv
// Scans every interior pixel of an IMG_W x IMG_H image, loads its 3x3
// neighbourhood into the window registers, runs the filter and stores the result.
module gauss_window_ctrl #(
    parameter int                IMG_W    = 8,
    parameter int                IMG_H    = 8,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] OUT_BASE = 'h0400
) (
    input logic                 clk,
    input logic                 rst,
    gauss_window_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_FIRE,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] x, x_nx;
    logic [ADDR_W-1:0] y, y_nx;
    logic [3:0]        k, k_nx;
    logic              done_q, done_nx;
    logic [7:0]        result_q, result_nx;

    logic [1:0]        k_row;
    logic [1:0]        k_col;
    logic [ADDR_W-1:0] rd_row;
    logic [ADDR_W-1:0] rd_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            x        <= '0;
            y        <= '0;
            k        <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_nx;
            x        <= x_nx;
            y        <= y_nx;
            k        <= k_nx;
            done_q   <= done_nx;
            result_q <= result_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        x_nx      = x;
        y_nx      = y;
        k_nx      = k;
        done_nx   = done_q;
        result_nx = result_q;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    x_nx     = ONE_A;
                    y_nx     = ONE_A;
                    k_nx     = '0;
                    done_nx  = 1'b0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (k == 4'd8) begin
                    state_nx = S_LAST;
                end else begin
                    k_nx = k + 4'd1;
                end
            end
            S_LAST:  state_nx = S_FIRE;
            S_FIRE:  state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.flt_done) begin
                    result_nx = bus.flt_result;
                    state_nx  = S_WRITE;
                end
            end
            S_WRITE: state_nx = S_NEXT;
            S_NEXT: begin
                k_nx = '0;
                if (x < X_LAST) begin
                    x_nx     = x + ONE_A;
                    state_nx = S_FETCH;
                end else if (y < Y_LAST) begin
                    x_nx     = ONE_A;
                    y_nx     = y + ONE_A;
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Neighbourhood offset of fetch step k: row k/3, column k%3.
    always_comb begin
        k_row = 2'd0;
        k_col = 2'd0;
        case (k)
            4'd0: begin k_row = 2'd0; k_col = 2'd0; end
            4'd1: begin k_row = 2'd0; k_col = 2'd1; end
            4'd2: begin k_row = 2'd0; k_col = 2'd2; end
            4'd3: begin k_row = 2'd1; k_col = 2'd0; end
            4'd4: begin k_row = 2'd1; k_col = 2'd1; end
            4'd5: begin k_row = 2'd1; k_col = 2'd2; end
            4'd6: begin k_row = 2'd2; k_col = 2'd0; end
            4'd7: begin k_row = 2'd2; k_col = 2'd1; end
            4'd8: begin k_row = 2'd2; k_col = 2'd2; end
            default: begin k_row = 2'd0; k_col = 2'd0; end
        endcase
    end

    assign rd_row = y + ADDR_W'(k_row) - ONE_A;
    assign rd_col = x + ADDR_W'(k_col) - ONE_A;

    // Outputs decode from registered state only, so reset forces them all low at once.
    always_comb begin
        bus.busy      = (state != S_IDLE) && (state != S_DONE);
        bus.done      = done_q;
        bus.mem_re    = 1'b0;
        bus.mem_raddr = '0;
        bus.win_we    = 1'b0;
        bus.win_addr  = '0;
        bus.win_pixel = '0;
        bus.flt_start = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        case (state)
            S_FETCH: begin
                bus.mem_re    = 1'b1;
                bus.mem_raddr = rd_row * IMG_W_A + rd_col;
                if (k != 4'd0) begin
                    bus.win_we    = 1'b1;
                    bus.win_addr  = k;
                    bus.win_pixel = bus.mem_rdata;
                end
            end
            S_LAST: begin
                bus.win_we    = 1'b1;
                bus.win_addr  = 4'd9;
                bus.win_pixel = bus.mem_rdata;
            end
            S_FIRE: bus.flt_start = 1'b1;
            S_WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = OUT_BASE + y * IMG_W_A + x;
                bus.mem_wdata = result_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Scoreboard bench for gauss_window_ctrl on a 4x4 image whose bytes equal their address;
// the filter model returns the window centre pixel XOR 8'h80.
module tb_gauss_window_ctrl;

    localparam int ADDR_W = 16;

    logic clk;
    logic rst;

    gauss_window_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    gauss_window_ctrl #(
        .IMG_W   (4),
        .IMG_H   (4),
        .ADDR_W  (ADDR_W),
        .OUT_BASE(16'h0400)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Hand-computed read addresses for pixels (1,1), (2,1), (1,2), (2,2).
    int rd_tab [0:35] = '{
        0, 1, 2, 4, 5, 6, 8, 9, 10,
        1, 2, 3, 5, 6, 7, 9, 10, 11,
        4, 5, 6, 8, 9, 10, 12, 13, 14,
        5, 6, 7, 9, 10, 11, 13, 14, 15
    };
    logic [15:0] wr_tab  [0:3] = '{16'h0405, 16'h0406, 16'h0409, 16'h040A};
    logic [7:0]  res_tab [0:3] = '{8'h85, 8'h86, 8'h89, 8'h8A};

    logic [ADDR_W-1:0] exp_rd [$];
    logic [11:0]       exp_win[$];
    logic [23:0]       exp_wr [$];

    int         stall_cfg   = 0;
    bit         inject_req  = 0;
    bit         inject_done = 0;
    int         fstarts     = 0;
    bit         stall_active = 0;
    bit         pend = 0;
    int         cnt  = 0;
    logic [7:0] res  = '0;
    bit         first_px;
    logic [7:0] win_buf [0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) bus.mem_rdata <= '0;
        else if (bus.mem_re) bus.mem_rdata <= bus.mem_raddr[7:0];
    end

    // Filter model: answers stall_cfg+1 WAIT cycles after flt_start for a frame's first pixel, else 1.
    always @(negedge clk) begin
        if (!rst) begin
            pend           = 0;
            cnt            = 0;
            stall_active   = 0;
            bus.flt_done   = 1'b0;
            bus.flt_result = '0;
        end else begin
            bus.flt_done = 1'b0;
            if (bus.win_we) win_buf[bus.win_addr] = bus.win_pixel;
            if (pend) begin
                if (cnt == 0) begin
                    bus.flt_done   = 1'b1;
                    bus.flt_result = res;
                    pend           = 0;
                    stall_active   = 0;
                end else begin
                    cnt--;
                end
            end
            if (bus.flt_start) begin
                first_px     = (fstarts % 4) == 0;
                cnt          = first_px ? stall_cfg : 0;
                res          = (first_px && stall_cfg != 0) ? 8'hA5 : (win_buf[5] ^ 8'h80);
                stall_active = cnt != 0;
                pend         = 1;
                fstarts++;
            end
            if (inject_req && !inject_done && bus.mem_re) begin
                bus.flt_done   = 1'b1;
                bus.flt_result = 8'hEE;
                inject_done    = 1;
            end
        end
    end

    function automatic logic [63:0] outputs_vec();
        return {6'd0, bus.busy, bus.done, bus.mem_re, bus.mem_raddr, bus.win_we, bus.win_addr,
                bus.win_pixel, bus.flt_start, bus.mem_we, bus.mem_waddr, bus.mem_wdata};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor_step();
        if (bus.mem_re || bus.mem_we)
            checkOutput("re_we_exclusive", 64'(bus.mem_re && bus.mem_we), 64'd0);
        if (stall_active)
            checkOutput("no_write_in_stall", 64'(bus.mem_we), 64'd0);
        if (bus.mem_re) begin
            if (exp_rd.size() == 0) checkOutput("unexpected_read", 64'(bus.mem_raddr), 64'hFFFF_FFFF);
            else checkOutput("read_addr", 64'(bus.mem_raddr), 64'(exp_rd.pop_front()));
        end
        if (bus.win_we) begin
            if (exp_win.size() == 0) checkOutput("unexpected_win", 64'({bus.win_addr, bus.win_pixel}), 64'hFFFF_FFFF);
            else checkOutput("win_load", 64'({bus.win_addr, bus.win_pixel}), 64'(exp_win.pop_front()));
        end
        if (bus.mem_we) begin
            if (exp_wr.size() == 0) checkOutput("unexpected_write", 64'({bus.mem_waddr, bus.mem_wdata}), 64'hFFFF_FFFF);
            else checkOutput("write", 64'({bus.mem_waddr, bus.mem_wdata}), 64'(exp_wr.pop_front()));
        end
    endtask

    task automatic push_frame(input bit stall);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 9; k++) exp_rd.push_back(ADDR_W'(rd_tab[p*9+k]));
            for (int s = 1; s <= 9; s++) exp_win.push_back({4'(s), 8'(rd_tab[p*9+s-1])});
            exp_wr.push_back({wr_tab[p], (stall && p == 0) ? 8'hA5 : res_tab[p]});
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input bit stall, input bit inject, input int exp_len);
        int n;
        int f0;
        push_frame(stall);
        stall_cfg = stall ? 20 : 0;
        f0 = fstarts;
        applyStimulus();
        checkOutput("done_cleared", 64'(bus.done), 64'd0);
        checkOutput("busy_set", 64'(bus.busy), 64'd1);
        n = 0;
        while (!bus.done && n < 2000) begin
            @(negedge clk);
            n++;
            if (inject) begin
                if (n == 3) inject_req = 1;
                if (n == 20) bus.start = 1'b1;
                if (n == 21) bus.start = 1'b0;
            end
        end
        checkOutput("frame_cycles", 64'(n), 64'(exp_len));
        checkOutput("busy_clear", 64'(bus.busy), 64'd0);
        checkOutput("flt_start_count", 64'(fstarts - f0), 64'd4);
        checkOutput("reads_left", 64'(exp_rd.size()), 64'd0);
        checkOutput("wins_left", 64'(exp_win.size()), 64'd0);
        checkOutput("writes_left", 64'(exp_wr.size()), 64'd0);
        stall_cfg  = 0;
        inject_req = 0;
        repeat (3) @(negedge clk);
        checkOutput("done_sticky", 64'(bus.done), 64'd1);
    endtask

    task automatic run_tests();
        // Abort a frame at fetch step 4 and make sure the block goes quiet.
        push_frame(0);
        applyStimulus();
        repeat (4) @(negedge clk);
        checkOutput("raddr_k4", 64'(bus.mem_raddr), 64'd5);
        #1 rst = 1'b0;
        #1 checkOutput("rst_async_outputs", outputs_vec(), 64'd0);
        exp_rd.delete();
        exp_win.delete();
        exp_wr.delete();
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs_held", outputs_vec(), 64'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_after_rst", 64'(bus.busy), 64'd0);

        run_frame(0, 0, 57);
        run_frame(0, 0, 57);
        run_frame(1, 0, 77);
        run_frame(0, 1, 57);
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        #2 rst     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", outputs_vec(), 64'd0);
        rst = 1'b1;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            run_tests();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
